// File: rtl/countdown_preset_timer.sv
// Preset countdown timer: synchronised buttons select a preset duration, a
// prescaler produces one-second ticks, and outputs are BCD MM:SS plus a session count.
module countdown_preset_timer #(
  parameter int TICK_DIV = 125000000,
  parameter int NUM_PRESETS = 4,
  parameter logic [NUM_PRESETS*16-1:0] PRESET_SEC = {16'd3000, 16'd1500, 16'd600, 16'd300}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PRESETS-1:0] btn,
  input  logic                   start_pause,
  output logic [15:0]            bcd_time,
  output logic [15:0]            bcd_count,
  output logic [1:0]             state,
  output logic                   done
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);

  logic [NUM_PRESETS-1:0] btn_s1, btn_s2, btn_d, btn_rise;
  logic                   sp_s1, sp_s2, sp_d, sp_rise;
  logic                   sel_hit;
  logic [IW-1:0]          sel_idx, idx;
  logic [12:0]            sel_sec, remaining;
  logic [PW-1:0]          presc;
  logic                   tick;
  logic [6:0]             mins;
  logic [5:0]             secs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= '0; btn_s2 <= '0; btn_d <= '0;
      sp_s1  <= 1'b0; sp_s2 <= 1'b0; sp_d <= 1'b0;
    end else begin
      btn_s1 <= btn;         btn_s2 <= btn_s1; btn_d <= btn_s2;
      sp_s1  <= start_pause; sp_s2  <= sp_s1;  sp_d  <= sp_s2;
    end
  end

  assign btn_rise = btn_s2 & ~btn_d;
  assign sp_rise  = sp_s2 & ~sp_d;

  // Descending scan so the lowest simultaneous edge is the one left standing.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    sel_sec = '0;
    for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
      if (btn_rise[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
        sel_sec = PRESET_SEC[i*16 +: 13];
      end
    end
  end

  assign tick = (state == RUN) && (presc == PRESC_TERM);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = (v != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      presc     <= '0;
      bcd_count <= '0;
      done      <= 1'b0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      if (sel_hit) begin
        idx       <= sel_idx;
        presc     <= '0;
        remaining <= sel_sec;
        state     <= (sel_sec == '0) ? IDLE : RUN;
        if (sel_idx != idx) bcd_count <= '0;
      end else begin
        case (state)
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && remaining == 13'd1) begin
              remaining <= '0;
              done      <= 1'b1;
              bcd_count <= bcd_inc(bcd_count);
              state     <= DONE;
            end else begin
              if (tick && remaining != '0) remaining <= remaining - 13'd1;
              if (sp_rise) state <= PAUSE;
            end
          end
          PAUSE: if (sp_rise) state <= RUN;
          default: ;
        endcase
      end
    end
  end

  assign mins = 7'(remaining / 13'd60);
  assign secs = 6'(remaining % 13'd60);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcd_time <= '0;
    else     bcd_time <= {4'(mins / 7'd10), 4'(mins % 7'd10), 4'(secs / 6'd10), 4'(secs % 6'd10)};
  end
endmodule

// File: tb/tb_countdown_preset_timer.sv
// Bench for countdown_preset_timer: per-cycle comparison against a behavioural
// model plus directed literal checks; a second small instance exercises count saturation.
module tb_countdown_preset_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = '0;
  logic        sp = 1'b0;
  logic [15:0] bcd_time, bcd_count;
  logic [1:0]  state;
  logic        done;

  logic        sbtn = 1'b0;
  logic        s_sp = 1'b0;
  logic [15:0] s_time, s_count;
  logic [1:0]  s_state;
  logic        s_done;

  int n_cmp = 0;
  int n_bad = 0;
  int sat_done_cnt = 0;

  always #5 clk = ~clk;

  countdown_preset_timer #(
    .TICK_DIV(4), .NUM_PRESETS(4),
    .PRESET_SEC({16'd0, 16'd61, 16'd2, 16'd3})
  ) u_dut (
    .clk(clk), .rst(rst), .btn(btn), .start_pause(sp),
    .bcd_time(bcd_time), .bcd_count(bcd_count), .state(state), .done(done)
  );

  countdown_preset_timer #(
    .TICK_DIV(2), .NUM_PRESETS(1), .PRESET_SEC(16'd1)
  ) u_sat (
    .clk(clk), .rst(rst), .btn(sbtn), .start_pause(s_sp),
    .bcd_time(s_time), .bcd_count(s_count), .state(s_state), .done(s_done)
  );

  always @(posedge clk) if (s_done) sat_done_cnt++;

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: seconds left, cycles into the current second, sessions done.
  int          sec_tab[4] = '{3, 2, 61, 0};
  int          m_state, m_rem, m_phase, m_count, m_idx, pick;
  bit          m_done, sev;
  logic [15:0] m_time;
  logic [3:0]  hb1, hb2, hb3;
  bit          hs1, hs2, hs3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_rem = 0; m_phase = 0; m_count = 0; m_idx = 0;
      m_done = 0; m_time = '0;
      hb1 = '0; hb2 = '0; hb3 = '0; hs1 = 0; hs2 = 0; hs3 = 0;
    end else begin
      m_time = to_bcd4((m_rem / 60) * 100 + m_rem % 60);
      m_done = 0;
      // An input is acted on at the third edge after it is first seen high.
      sev  = hs2 && !hs3;
      pick = -1;
      for (int i = 0; i < 4; i++) if (pick < 0 && hb2[i] && !hb3[i]) pick = i;
      if (pick >= 0) begin
        if (pick != m_idx) m_count = 0;
        m_idx   = pick;
        m_rem   = sec_tab[pick];
        m_phase = 0;
        m_state = (m_rem != 0) ? 1 : 0;
      end else if (m_state == 1) begin
        m_phase++;
        if (m_phase == 4) begin
          m_phase = 0;
          if (m_rem == 1) begin
            m_rem = 0; m_done = 1; m_state = 3;
            m_count = (m_count < 9999) ? m_count + 1 : 9999;
          end else if (m_rem > 1) m_rem--;
        end
        if (m_state == 1 && sev) m_state = 2;
      end else if (m_state == 2 && sev) begin
        m_state = 1;
      end
      hb3 = hb2; hb2 = hb1; hb1 = btn;
      hs3 = hs2; hs2 = hs1; hs1 = sp;
    end
  end

  always @(negedge clk) begin
    n_cmp += 4;
    if (state !== 2'(m_state)) begin
      n_bad++; $display("FAIL cyc_state @%0t: got %0d expected %0d", $time, state, m_state);
    end
    if (bcd_time !== m_time) begin
      n_bad++; $display("FAIL cyc_time @%0t: got %h expected %h", $time, bcd_time, m_time);
    end
    if (bcd_count !== to_bcd4(m_count)) begin
      n_bad++; $display("FAIL cyc_count @%0t: got %h expected %h", $time, bcd_count, to_bcd4(m_count));
    end
    if (done !== m_done) begin
      n_bad++; $display("FAIL cyc_done @%0t: got %b expected %b", $time, done, m_done);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m, input logic s);
    @(posedge clk); #1;
    btn = m; sp = s;
    @(posedge clk); #1;
    btn = '0; sp = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    step(3);
    lit("rst_state", 16'(state), 16'd0);
    lit("rst_time", bcd_time, 16'h0000);
    lit("rst_count", bcd_count, 16'h0000);
    lit("rst_done", 16'(done), 16'd0);
    rst = 1'b0;
    step(2);

    // preset 0: 3 s countdown to completion
    pulse(4'b0001, 1'b0);
    step(3); lit("p0_state_run", 16'(state), 16'd1); lit("p0_t3", bcd_time, 16'h0003);
    step(4); lit("p0_t2", bcd_time, 16'h0002);
    step(4); lit("p0_t1", bcd_time, 16'h0001);
    step(3); lit("p0_done", 16'(done), 16'd1); lit("p0_state_done", 16'(state), 16'd3);
    lit("p0_count", bcd_count, 16'h0001);
    step(1); lit("p0_done_low", 16'(done), 16'd0); lit("p0_t0", bcd_time, 16'h0000);
    step(5); lit("p0_hold", bcd_count, 16'h0001);
    pulse(4'b0000, 1'b1);
    step(4); lit("sp_in_done", 16'(state), 16'd3);

    // preset 2: 61 s, count cleared on index change
    pulse(4'b0100, 1'b0);
    step(3); lit("p2_t0101", bcd_time, 16'h0101); lit("p2_count_clr", bcd_count, 16'h0000);
    step(4); lit("p2_t0100", bcd_time, 16'h0100);

    // pause/resume with frozen prescaler
    pulse(4'b0000, 1'b1);
    step(2); lit("pause_state", 16'(state), 16'd2); lit("pause_t", bcd_time, 16'h0059);
    step(20); lit("pause_hold_state", 16'(state), 16'd2); lit("pause_hold_t", bcd_time, 16'h0059);
    pulse(4'b0000, 1'b1);
    step(2); lit("resume_state", 16'(state), 16'd1);
    step(3); lit("resume_t59", bcd_time, 16'h0059);
    step(1); lit("resume_t58", bcd_time, 16'h0058);

    // simultaneous edges
    pulse(4'b0011, 1'b0);
    step(3); lit("lowest_idx", bcd_time, 16'h0003); lit("lowest_state", 16'(state), 16'd1);
    pulse(4'b0010, 1'b1);
    step(3); lit("sel_over_sp_t", bcd_time, 16'h0002); lit("sel_over_sp_st", 16'(state), 16'd1);
    step(3); lit("sel_over_sp_run", 16'(state), 16'd1);

    // zero-length preset
    pulse(4'b1000, 1'b0);
    step(3); lit("zero_state", 16'(state), 16'd0); lit("zero_t", bcd_time, 16'h0000);
    lit("zero_done", 16'(done), 16'd0);
    pulse(4'b0000, 1'b1);
    step(4); lit("sp_in_idle", 16'(state), 16'd0);

    // reset mid-run, with a nonzero count and same-index reselect
    pulse(4'b0001, 1'b0);
    step(16); lit("rerun_count", bcd_count, 16'h0001);
    pulse(4'b0001, 1'b0);
    step(3); lit("same_idx_keep", bcd_count, 16'h0001);
    step(3);
    rst = 1'b1; #1;
    lit("mid_rst_state", 16'(state), 16'd0);
    lit("mid_rst_time", bcd_time, 16'h0000);
    lit("mid_rst_count", bcd_count, 16'h0000);
    lit("mid_rst_done", 16'(done), 16'd0);
    step(2);
    rst = 1'b0;
    step(10); lit("post_rst_idle", 16'(state), 16'd0); lit("post_rst_t", bcd_time, 16'h0000);

    // saturation on a fast 1 s, 2-clk-tick instance
    for (int k = 1; k <= 9999; k++) begin
      sbtn = 1'b1; step(2);
      sbtn = 1'b0; step(2);
      if (k == 10) begin
        step(4); lit("sat_10", s_count, 16'h0010);
      end
    end
    step(4);
    lit("sat_9999", s_count, 16'h9999);
    lit("sat_state", 16'(s_state), 16'd3);
    sbtn = 1'b1; step(2);
    sbtn = 1'b0; step(6);
    lit("sat_hold", s_count, 16'h9999);
    lit("sat_done_pulses", 16'(sat_done_cnt), 16'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
